pipe_add_seg: RTL

- Parametrised, segmented pipelined adder; successor to the fixed 8-bit two-operand pipelined adder.
- The WIDTH-bit carry chain is split into STAGES equal segments, one segment per pipeline stage; carry ripples stage-to-stage through registers.
- Adds carry-in, signed/unsigned mode, an overflow flag and valid/ready flow control with full backpressure.
- Sits between datapath producers and consumers that need wide adds at high clock rate.

---
 rtl/pipe_add_seg_if.sv | 28 ++
 rtl/pipe_add_seg.sv | 109 ++++++++++
 2 files changed

// File: rtl/pipe_add_seg_if.sv
// Operand/result handshake bundle for the segmented pipelined adder.
// Carries no state; timing is set entirely by the module on the slave side.
// Backpressure: in_ready/out_ready form a valid-ready pair on each side.
interface pipe_add_seg_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   sum;
   logic             ovf;

   // Adder side: consumes operands, produces results.
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, ovf
   );

   // Producer/consumer side: drives operands and result acceptance.
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, ovf
   );
endinterface

// File: rtl/pipe_add_seg.sv
// Segmented pipelined adder: WIDTH-bit add split into STAGES ripple segments, carry registered between stages.
// Latency: STAGES cycles from accept to out_valid; throughput 1/cycle, bubbles are not collapsed.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready = !out_valid || out_ready.
module pipe_add_seg #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int SIGNED = 0
) (
   input  logic          clk,
   input  logic          rst,
   pipe_add_seg_if.slave bus
);
   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipe_add_seg: STAGES must divide WIDTH and lie in 1..WIDTH");
   end

   // Stage registers: valid, operand copies, partial result, segment carry-out.
   logic             vld_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] res_q [STAGES];
   logic             c_q   [STAGES];

   // What each stage sees at its input, and what it would capture.
   logic             pv    [STAGES];
   logic [WIDTH-1:0] pa    [STAGES];
   logic [WIDTH-1:0] pb    [STAGES];
   logic [WIDTH-1:0] pr    [STAGES];
   logic             pc    [STAGES];
   logic [WIDTH-1:0] res_n [STAGES];
   logic             c_n   [STAGES];

   logic en;
   logic cout, amsb, bmsb, rmsb;

   // Whole pipe advances together; a stalled result freezes every stage.
   assign en           = !vld_q[LAST] || bus.out_ready;
   assign bus.in_ready = en;

   // Stage k adds its segment with the carry from the stage before it.
   always_comb begin
      logic [SEG:0] seg;
      seg = '0;
      for (int k = 0; k < STAGES; k++) begin
         pv[k]    = 1'b0;
         pa[k]    = '0;
         pb[k]    = '0;
         pr[k]    = '0;
         pc[k]    = 1'b0;
         res_n[k] = '0;
         c_n[k]   = 1'b0;
      end
      pv[0] = bus.in_valid;
      pa[0] = bus.a;
      pb[0] = bus.b;
      pr[0] = '0;
      pc[0] = bus.cin;
      for (int k = 1; k < STAGES; k++) begin
         pv[k] = vld_q[k-1];
         pa[k] = a_q[k-1];
         pb[k] = b_q[k-1];
         pr[k] = res_q[k-1];
         pc[k] = c_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]} + {{SEG{1'b0}}, pc[k]};
         res_n[k] = pr[k];
         res_n[k][k*SEG +: SEG] = seg[SEG-1:0];
         c_n[k] = seg[SEG];
      end
   end

   // Valid bits shift on every advance; data only loads behind a valid, so
   // the output keeps its last result through bubbles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            res_q[k] <= '0;
            c_q[k]   <= 1'b0;
         end
      end else if (en) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_q[k] <= pv[k];
            if (pv[k]) begin
               a_q[k]   <= pa[k];
               b_q[k]   <= pb[k];
               res_q[k] <= res_n[k];
               c_q[k]   <= c_n[k];
            end
         end
      end
   end

   // Carry into the MSB is recovered as a^b^result at that bit.
   assign cout = c_q[LAST];
   assign amsb = a_q[LAST][WIDTH-1];
   assign bmsb = b_q[LAST][WIDTH-1];
   assign rmsb = res_q[LAST][WIDTH-1];

   assign bus.out_valid = vld_q[LAST];
   assign bus.sum       = {(SIGNED != 0) ? (amsb ^ bmsb ^ cout) : cout, res_q[LAST]};
   assign bus.ovf       = (SIGNED != 0) ? (amsb ^ bmsb ^ rmsb ^ cout) : cout;
endmodule
